// File: rtl/node_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : node_pkg
//  Description : Shared constants for the sequential neuron MAC slice:
//                floating-point word width, the +0.0 encoding and the
//                state encoding of the node_mac_seq controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package node_pkg;

    localparam int              FP_W    = 32;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    // Controller state encoding
    localparam int              c_ST_W      = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_RUN    = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_FINISH = 2'd2;
    localparam logic [c_ST_W-1:0] c_ST_BIAS   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/node_relu.sv
`default_nettype none
// ============================================================================
//  Module      : node_relu
//  Description : ReLU clamp on an IEEE-754 single. Any value with the sign
//                bit set (negative numbers and -0.0) becomes +0.0.
//  Ports       : sum      - unclamped float sum
//                relu_out - clamped result
//  Revision    : 1.0 - initial release
// ============================================================================
module node_relu
    import node_pkg::*;
(
    input  logic [FP_W-1:0] sum,
    output logic [FP_W-1:0] relu_out
);

    assign relu_out = sum[FP_W-1] ? FP_ZERO : sum;

endmodule
`default_nettype wire

// File: rtl/node_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : node_mac_seq
//  Description : Sequential single-neuron multiply-accumulate. Walks the
//                shared activation/weight memories one address per cycle,
//                accumulates a*w through an external combinational
//                float_mult/float_adder pair, and publishes the ReLU-clamped
//                sum with a one-cycle done pulse.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start               - request an evaluation (ignored if busy)
//                busy, done          - in-progress flag, result-valid pulse
//                op_addr             - read address for both operand memories
//                a_data, w_data      - operands, valid one cycle after op_addr
//                mult_x/y, mult_z    - shared float_mult operands / product
//                add_a/b, add_out    - shared float_adder operands / sum
//                result              - ReLU-clamped neuron output
//                bias                - (NODE_BIAS_EN only) added after the
//                                      last accumulation in state BIAS
//  Config      : define NODE_BIAS_EN to add the bias port and BIAS state.
//  Revision    : 1.0 - initial release
// ============================================================================
module node_mac_seq
    import node_pkg::*;
#(
    parameter int N_INPUTS = 187,
    parameter int ADDR_W   = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef NODE_BIAS_EN
    input  logic [FP_W-1:0]   bias,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] op_addr,
    input  logic [FP_W-1:0]   a_data,
    input  logic [FP_W-1:0]   w_data,
    output logic [FP_W-1:0]   mult_x,
    output logic [FP_W-1:0]   mult_y,
    input  logic [FP_W-1:0]   mult_z,
    output logic [FP_W-1:0]   add_a,
    output logic [FP_W-1:0]   add_b,
    input  logic [FP_W-1:0]   add_out,
    output logic [FP_W-1:0]   result
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(N_INPUTS - 1);

    // State in which the final sum appears on add_out and result is loaded
`ifdef NODE_BIAS_EN
    localparam logic [c_ST_W-1:0] c_ST_RESULT = c_ST_BIAS;
`else
    localparam logic [c_ST_W-1:0] c_ST_RESULT = c_ST_FINISH;
`endif

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_next;
    logic [ADDR_W-1:0] r_index;
    logic              r_valid;   // a_data/w_data hold the operand of last cycle's address
    logic              r_done;
    logic [FP_W-1:0]   r_acc;
    logic [FP_W-1:0]   r_result;
    logic [FP_W-1:0]   w_relu;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (start) w_next = c_ST_RUN;
            c_ST_RUN:    if (r_index == c_LAST) w_next = c_ST_FINISH;
`ifdef NODE_BIAS_EN
            c_ST_FINISH: w_next = c_ST_BIAS;
            c_ST_BIAS:   w_next = c_ST_IDLE;
`else
            c_ST_FINISH: w_next = c_ST_IDLE;
`endif
            default:     w_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (r_state != c_ST_IDLE);
        op_addr = (r_state == c_ST_RUN) ? r_index : '0;
        mult_x  = FP_ZERO;
        mult_y  = FP_ZERO;
        add_a   = FP_ZERO;
        add_b   = FP_ZERO;
        if (r_valid) begin
            mult_x = a_data;
            mult_y = w_data;
            add_a  = r_acc;
            add_b  = mult_z;
        end
`ifdef NODE_BIAS_EN
        else if (r_state == c_ST_BIAS) begin
            add_a = r_acc;
            add_b = bias;
        end
`endif
    end

    // The final sum is on add_out in the result-load state, so clamp it
    // directly rather than waiting for it to land in the accumulator.
    node_relu u_relu (
        .sum      (add_out),
        .relu_out (w_relu)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index  <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= FP_ZERO;
            r_result <= FP_ZERO;
        end else begin
            r_done  <= 1'b0;
            r_valid <= (r_state == c_ST_RUN);

            if (r_state == c_ST_IDLE && start) begin
                r_acc   <= FP_ZERO;
                r_index <= '0;
            end else if (r_state == c_ST_RUN && r_index != c_LAST) begin
                r_index <= r_index + 1'b1;
            end

            // r_valid is never set in IDLE, so this cannot collide with the clear
            if (r_valid) begin
                r_acc <= add_out;
            end

            if (r_state == c_ST_RESULT) begin
                r_result <= w_relu;
                r_done   <= 1'b1;
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_node_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_node_mac_seq
//  Description : Directed self-checking bench for node_mac_seq with
//                N_INPUTS=2. Behavioural float multiplier/adder and
//                registered operand memories surround the DUT; expected
//                results go into a scoreboard queue at start and are
//                popped when done rises.
//  Config      : NODE_BIAS_EN selects the bias variant expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_node_mac_seq;

    localparam int N_IN = 2;

`ifdef NODE_BIAS_EN
    localparam logic [31:0] EXP_T1 = 32'h0000_0000;   // 6.0 + -10.0 -> clamped
    localparam int          LAT    = 5;
`else
    localparam logic [31:0] EXP_T1 = 32'h40C0_0000;   // 1*2 + 2*2 = 6.0
    localparam int          LAT    = 4;
`endif
    localparam logic [31:0] EXP_T2 = 32'h0000_0000;   // -4.0 clamped

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done;
    logic [7:0]  op_addr;
    logic [31:0] a_data, w_data;
    logic [31:0] mult_x, mult_y, mult_z;
    logic [31:0] add_a, add_b, add_out;
    logic [31:0] result;
`ifdef NODE_BIAS_EN
    logic [31:0] bias = 32'hC120_0000;
`endif

    logic [31:0] a_mem [2];
    logic [31:0] w_mem [2];
    logic [31:0] exp_q [$];
    logic [31:0] last_result = 32'h0;
    int          ncmp = 0;
    int          nfail = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    // Single <-> double conversion for normal numbers and zero
    function automatic real sp2r(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'h0) return s[31] ? -0.0 : 0.0;
        e = 11'(s[30:23]) + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'h0) return {b[63], 31'h0};
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    assign mult_z  = r2sp(sp2r(mult_x) * sp2r(mult_y));
    assign add_out = r2sp(sp2r(add_a) + sp2r(add_b));

    always @(posedge clk) begin
        a_data <= a_mem[op_addr[0]];
        w_data <= w_mem[op_addr[0]];
    end

    always @(posedge clk) if (done) done_cnt++;

    node_mac_seq #(.N_INPUTS(N_IN), .ADDR_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
`ifdef NODE_BIAS_EN
        .bias    (bias),
`endif
        .busy    (busy),
        .done    (done),
        .op_addr (op_addr),
        .a_data  (a_data),
        .w_data  (w_data),
        .mult_x  (mult_x),
        .mult_y  (mult_y),
        .mult_z  (mult_z),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_out (add_out),
        .result  (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] a0, a1, w0, w1);
        a_mem[0] = a0; a_mem[1] = a1;
        w_mem[0] = w0; w_mem[1] = w1;
    endtask

    task automatic start_eval(input logic [31:0] exp);
        @(posedge clk); #1;
        start = 1'b1;
        exp_q.push_back(exp);
    endtask

    // lat counts edges after the cycle in which start was driven
    task automatic wait_done(input int rpulse, input bit hold, output int lat);
        lat = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            start = hold || (lat == rpulse);
            @(negedge clk);
            if (done) break;
            if (lat <= N_IN) chk("op_addr", 32'(op_addr), 32'(lat - 1));
            chk("result_hold", result, last_result);
            if (lat > 30) begin
                ncmp++;
                nfail++;
                $error("FAIL done_timeout: observed no done after %0d cycles, required %0d", lat, LAT);
                break;
            end
        end
    endtask

    task automatic check_done(input int lat);
        logic [31:0] exp;
        chk("latency", 32'(lat), 32'(LAT));
        chk("busy_in_done", 32'(busy), 32'h0);
        chk("mult_x_idle", mult_x, 32'h0);
        chk("add_a_idle", add_a, 32'h0);
        if (exp_q.size() == 0) begin
            ncmp++;
            nfail++;
            $error("FAIL scoreboard: observed done with empty queue, required a pending result");
        end else begin
            exp = exp_q.pop_front();
            chk("result", result, exp);
            last_result = exp;
        end
    endtask

    initial begin
        int lat;
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        load(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_done",    32'(done),    32'h0);
        chk("rst_op_addr", 32'(op_addr), 32'h0);
        chk("rst_result",  result,       32'h0);
        chk("rst_add_b",   add_b,        32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Test 1: 1*2 + 2*2
        start_eval(EXP_T1);
        wait_done(0, 1'b0, lat);
        check_done(lat);

        // Test 2: -1*2 + -1*2 = -4.0, clamped; prior result must hold meanwhile
        load(32'hBF80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h4000_0000);
        start_eval(EXP_T2);
        wait_done(0, 1'b0, lat);
        check_done(lat);

        // Test 3: extra start at cycle 2 is ignored, exactly one done
        load(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        start_eval(EXP_T1);
        wait_done(2, 1'b0, lat);
        check_done(lat);
        d0 = done_cnt;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("single_done", 32'(done_cnt), 32'(d0 + 1));
        chk("idle_after_ignore", 32'(busy), 32'h0);

        // Test 4: reset at cycle 2 aborts, start accepted on first edge after
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("abort_busy",    32'(busy),    32'h0);
        chk("abort_done",    32'(done),    32'h0);
        chk("abort_op_addr", 32'(op_addr), 32'h0);
        chk("abort_result",  result,       32'h0);
        chk("abort_mult_y",  mult_y,       32'h0);
        last_result = 32'h0;
        exp_q.push_back(EXP_T1);
        wait_done(0, 1'b0, lat);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        check_done(lat);

        // Test 5: start held across done -> back-to-back evaluations
        start_eval(EXP_T1);
        wait_done(0, 1'b1, lat);
        check_done(lat);
        exp_q.push_back(EXP_T1);
        wait_done(0, 1'b0, lat);
        check_done(lat);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/node_mac_seq.md
NODE_MAC_SEQ -- requirements
Module: node_mac_seq

Interface
REQ-001 The parameter N_INPUTS SHALL default to 187 and set the number of input/weight pairs per neuron; legal range is 1..4096.
REQ-002 The parameter ADDR_W SHALL default to 8 and set the operand address width; it SHALL satisfy 2^ADDR_W >= N_INPUTS.
REQ-003 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state changes on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, and is a synchronous, active-high reset.
REQ-005 The port start SHALL be an input, 1 bit wide, and requests one neuron evaluation.
REQ-006 The port busy SHALL be an output, 1 bit wide, and is high while an evaluation is in progress.
REQ-007 The port done SHALL be an output, 1 bit wide, and is a one-cycle pulse that marks result valid.
REQ-008 The port op_addr SHALL be an output, ADDR_W bits wide, and is the shared read address for the activation and weight memories.
REQ-009 The ports a_data and w_data SHALL be inputs, 32 bits wide, carrying IEEE-754 single-precision activation and weight, valid one cycle after op_addr.
REQ-010 The ports mult_x and mult_y SHALL be outputs and mult_z an input, each 32 bits wide, connecting to the shared combinational float_mult.
REQ-011 The ports add_a and add_b SHALL be outputs and add_out an input, each 32 bits wide, connecting to the shared combinational float_adder.
REQ-012 The port result SHALL be an output, 32 bits wide, carrying the ReLU-clamped neuron output.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, FINISH (plus BIAS under NODE_BIAS_EN); busy=1 in every state except IDLE.
REQ-014 start SHALL be sampled only when busy=0; start while busy=1 SHALL be ignored with no effect.
REQ-015 On accepted start at edge T0: accumulator SHALL be cleared to 0x00000000, index set to 0, and the state SHALL go to RUN.
REQ-016 In RUN, op_addr SHALL equal the index, incrementing by 1 per cycle from 0 to N_INPUTS-1; when op_addr=N_INPUTS-1 is issued, the next state SHALL be FINISH.
REQ-017 A one-cycle-delayed valid flag SHALL mark the cycles where a_data/w_data are valid; in those cycles mult_x=a_data, mult_y=w_data, add_a=accumulator, add_b=mult_z, and the accumulator SHALL load add_out.
REQ-018 FINISH SHALL perform the last accumulation (index N_INPUTS-1), then register result and go to IDLE.
REQ-019 In the cycle after FINISH, done SHALL be 1 and busy SHALL be 0, so the total latency is N_INPUTS+2 cycles from the start edge to done high.
REQ-020 ReLU rule: if the final sum bit31=0, result SHALL be the sum; otherwise, including -0.0, result SHALL be 0x00000000.
REQ-021 result SHALL hold its value until the next done; it SHALL NOT change mid-evaluation.
REQ-022 start asserted in the done cycle SHALL be accepted, giving back-to-back evaluations with no idle gap.
REQ-023 When not accumulating, the mult_x, mult_y, add_a and add_b outputs SHALL be driven to 0x00000000.
REQ-024 N_INPUTS=1 SHALL give RUN for one cycle, then FINISH, with done at start+3.

Reset
REQ-025 rst SHALL force state=IDLE, busy=0, done=0, op_addr=0, result=0, accumulator=0, valid flag=0; rst has priority over start.
REQ-026 rst during an evaluation SHALL abort it with no done pulse, and start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-027 With macro NODE_BIAS_EN defined, the block SHALL add a 32-bit input bias and a state BIAS between FINISH and IDLE that computes accumulator+bias via the shared adder, making the latency N_INPUTS+3.
REQ-028 Without NODE_BIAS_EN, the bias port and the BIAS state SHALL be absent, and the latency SHALL be N_INPUTS+2.

Structure
REQ-029 The shared package node_pkg SHALL hold FP_W=32, FP_ZERO=32'h00000000 and the FSM state encoding.
REQ-030 The ReLU clamp SHALL be a sub-module node_relu; float_mult and float_adder SHALL remain external shared instances.

Verification
REQ-031 Test 1: N_INPUTS=2, a={0x3F800000, 0x40000000}, w={0x40000000, 0x40000000} -> result=0x40C00000 (6.0), done exactly 4 cycles after start.
REQ-032 Test 2: N_INPUTS=2, a={0xBF800000, 0xBF800000}, w={0x40000000, 0x40000000} -> the -4.0 sum SHALL be clamped, giving result=0x00000000 and done at cycle 4.
REQ-033 Test 3: start pulsed again at cycle 2 of a running evaluation -> ignored, a single done at cycle 4, and op_addr sequence 0,1 only.
REQ-034 Test 4: rst asserted at cycle 2 -> no done, all outputs 0 the next cycle, and a new start then completes normally with result 0x40C00000.
REQ-035 Test 5: start held high across done -> the second evaluation starts in the done cycle, and op_addr=0 in the following cycle.
REQ-036 Test 6: NODE_BIAS_EN defined, Test 1 data, bias=0xC1200000 (-10.0) -> the sum -4.0 SHALL be clamped, giving result=0x00000000, with done at cycle 5.
